// File: rtl/cache_arbiter_pkg.sv
// Shared memory-hierarchy types for the cache/physical-memory path.
//   LINE_W_DEF / ADDR_W_DEF : default line width and byte-address width
//   LINE_OFFSET_W           : byte-offset bits inside one 32-byte line
//   arb_state_t             : arbiter FSM state
//   req_id_t                : which cache a transaction belongs to
//   pmem_op_t               : operation currently presented to physical memory
package cache_arbiter_pkg;

   localparam int LINE_W_DEF    = 256;
   localparam int ADDR_W_DEF    = 32;
   localparam int LINE_OFFSET_W = 5;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } arb_state_t;

   typedef enum logic {
      REQ_I = 1'b0,
      REQ_D = 1'b1
   } req_id_t;

   typedef enum logic [1:0] {
      OP_NONE  = 2'd0,
      OP_READ  = 2'd1,
      OP_WRITE = 2'd2
   } pmem_op_t;

endpackage

// File: rtl/cache_arbiter.sv
// Arbiter sharing one physical-memory port between the I-cache and D-cache.
// Ports:
//   clk, rst_n                              clock, synchronous active-low reset
//   icache_pmem_read/address                I-cache line-fill request
//   icache_pmem_rdata/resp                  I-cache fill data and done pulse
//   dcache_pmem_read/write/address/wdata    D-cache fill / writeback request
//   dcache_pmem_rdata/resp                  D-cache fill data and done pulse
//   pmem_read/write/address/wdata           registered request to physical memory
//   pmem_rdata/resp                         physical-memory reply
// One transaction is in flight at a time. A grant latches the request, so the
// memory sees it one cycle after it is first seen in IDLE and it stays frozen
// until pmem_resp, regardless of what the requester does meanwhile.
module cache_arbiter
   import cache_arbiter_pkg::*;
#(
   parameter int LINE_W = LINE_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              icache_pmem_read,
   input  logic [ADDR_W-1:0] icache_pmem_address,
   output logic [LINE_W-1:0] icache_pmem_rdata,
   output logic              icache_pmem_resp,
   input  logic              dcache_pmem_read,
   input  logic              dcache_pmem_write,
   input  logic [ADDR_W-1:0] dcache_pmem_address,
   input  logic [LINE_W-1:0] dcache_pmem_wdata,
   output logic [LINE_W-1:0] dcache_pmem_rdata,
   output logic              dcache_pmem_resp,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_address,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp
);

   arb_state_t        state_q, state_d;
   req_id_t           last_q, last_d;
   pmem_op_t          op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LINE_W-1:0] wdata_q, wdata_d;

   logic    i_pend, d_pend;
   req_id_t pick;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         last_q  <= REQ_I;  // makes the D-cache win the first tie
         op_q    <= OP_NONE;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      last_d           = last_q;
      op_d             = op_q;
      addr_d           = addr_q;
      wdata_d          = wdata_q;
      icache_pmem_resp = 1'b0;
      dcache_pmem_resp = 1'b0;

      i_pend = icache_pmem_read;
      d_pend = dcache_pmem_read | dcache_pmem_write;

      // On a tie the requester not served last wins.
      pick = REQ_D;
      if (i_pend && d_pend) begin
         pick = (last_q == REQ_I) ? REQ_D : REQ_I;
      end else if (i_pend) begin
         pick = REQ_I;
      end

      case (state_q)
         IDLE: begin
            // A stray pmem_resp here is deliberately not forwarded.
            if (i_pend || d_pend) begin
               if (pick == REQ_I) begin
                  state_d = SERVE_I;
                  op_d    = OP_READ;
                  addr_d  = {icache_pmem_address[ADDR_W-1:LINE_OFFSET_W],
                             {LINE_OFFSET_W{1'b0}}};
                  wdata_d = '0;
               end else begin
                  state_d = SERVE_D;
                  // Read and write together is treated as a writeback.
                  op_d    = dcache_pmem_write ? OP_WRITE : OP_READ;
                  addr_d  = {dcache_pmem_address[ADDR_W-1:LINE_OFFSET_W],
                             {LINE_OFFSET_W{1'b0}}};
                  wdata_d = dcache_pmem_wdata;
               end
            end
         end
         SERVE_I: begin
            icache_pmem_resp = pmem_resp;
            if (pmem_resp) begin
               state_d = IDLE;
               op_d    = OP_NONE;
               last_d  = REQ_I;
            end
         end
         SERVE_D: begin
            dcache_pmem_resp = pmem_resp;
            if (pmem_resp) begin
               state_d = IDLE;
               op_d    = OP_NONE;
               last_d  = REQ_D;
            end
         end
         default: begin
            state_d = IDLE;
            op_d    = OP_NONE;
         end
      endcase
   end

   assign pmem_read         = (op_q == OP_READ);
   assign pmem_write        = (op_q == OP_WRITE);
   assign pmem_address      = addr_q;
   assign pmem_wdata        = wdata_q;
   assign icache_pmem_rdata = pmem_rdata;
   assign dcache_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
module tb_cache_arbiter;

   localparam int LW = 256;
   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          ir;
   logic [AW-1:0] iaddr;
   logic [LW-1:0] irdata;
   logic          iresp;
   logic          dr, dw;
   logic [AW-1:0] daddr;
   logic [LW-1:0] dwdata;
   logic [LW-1:0] drdata;
   logic          dresp;
   logic          p_rd, p_wr;
   logic [AW-1:0] p_addr;
   logic [LW-1:0] p_wdata;
   logic [LW-1:0] p_rdata;
   logic          p_resp;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   cache_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .icache_pmem_read    (ir),
      .icache_pmem_address (iaddr),
      .icache_pmem_rdata   (irdata),
      .icache_pmem_resp    (iresp),
      .dcache_pmem_read    (dr),
      .dcache_pmem_write   (dw),
      .dcache_pmem_address (daddr),
      .dcache_pmem_wdata   (dwdata),
      .dcache_pmem_rdata   (drdata),
      .dcache_pmem_resp    (dresp),
      .pmem_read           (p_rd),
      .pmem_write          (p_wr),
      .pmem_address        (p_addr),
      .pmem_wdata          (p_wdata),
      .pmem_rdata          (p_rdata),
      .pmem_resp           (p_resp)
   );

   // Transaction-level reference: at most one outstanding memory transaction.
   bit          mdl_on = 0;
   bit          m_busy;      // a transaction is being presented to memory
   bit          m_is_d;      // owner of that transaction
   bit          m_write;
   bit          m_last_d;    // D-cache was the last one completed
   bit          m_fresh;     // reset seen, nothing granted since
   logic [AW-1:0] m_addr;
   logic [LW-1:0] m_wdata;

   task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_compare();
      chk("m_pmem_read",  p_rd,  m_busy && !m_write);
      chk("m_pmem_write", p_wr,  m_busy && m_write);
      chk("m_iresp",      iresp, m_busy && !m_is_d && p_resp);
      chk("m_dresp",      dresp, m_busy && m_is_d && p_resp);
      chk("m_irdata",     irdata, p_rdata);
      chk("m_drdata",     drdata, p_rdata);
      if (m_busy || m_fresh) chk("m_addr", p_addr, m_addr);
      if ((m_busy && m_write) || m_fresh) chk("m_wdata", p_wdata, m_wdata);
   endtask

   task automatic model_advance();
      bit want_i, want_d, give_d;
      want_i = ir;
      want_d = dr || dw;
      if (!rst_n) begin
         m_busy = 0; m_last_d = 0; m_fresh = 1; m_addr = '0; m_wdata = '0; m_write = 0;
      end else if (m_busy) begin
         if (p_resp) begin
            m_busy   = 0;
            m_last_d = m_is_d;
         end
      end else if (want_i || want_d) begin
         if (want_i && want_d) give_d = m_last_d ? 1'b0 : 1'b1;
         else                  give_d = want_d;
         m_busy  = 1;
         m_fresh = 0;
         m_is_d  = give_d;
         if (give_d) begin
            m_addr  = daddr & ~32'h1F;
            m_write = dw;
            m_wdata = dwdata;
         end else begin
            m_addr  = iaddr & ~32'h1F;
            m_write = 0;
         end
      end
   endtask

   // One clock: compare mid-cycle, advance the reference, cross the edge.
   task automatic cyc();
      #1;
      if (mdl_on) model_compare();
      model_advance();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_inputs();
      ir = 0; dr = 0; dw = 0; p_resp = 0;
   endtask

   initial begin
      rst_n = 0; idle_inputs();
      iaddr = '0; daddr = '0; dwdata = '0; p_rdata = '0;
      @(posedge clk); #2;

      // ---- reset state
      cyc();
      mdl_on = 1;
      cyc();
      #1;
      chk("rst_pmem_read",  p_rd,    1'b0);
      chk("rst_pmem_write", p_wr,    1'b0);
      chk("rst_addr",       p_addr,  '0);
      chk("rst_wdata",      p_wdata, '0);
      chk("rst_iresp",      iresp,   1'b0);
      chk("rst_dresp",      dresp,   1'b0);
      rst_n = 1;

      // ---- I-only read
      ir = 1; iaddr = 32'h0000_0064;
      #1; chk("i_not_yet", p_rd, 1'b0);
      cyc();
      #1;
      chk("i_pmem_read", p_rd, 1'b1);
      chk("i_addr", p_addr, 32'h0000_0060);
      cyc();
      p_rdata = {32{8'hA5}}; p_resp = 1; ir = 0;
      #1;
      chk("i_resp",  iresp,  1'b1);
      chk("i_rdata", irdata, {32{8'hA5}});
      chk("i_dresp", dresp,  1'b0);
      cyc();
      p_resp = 0;
      #1; chk("i_done_read", p_rd, 1'b0);
      cyc();

      // ---- D write held through a 5-cycle response delay
      dw = 1; daddr = 32'h0000_1000; dwdata = 256'hDEAD_BEEF;
      cyc();
      dw = 0;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("dw_write", p_wr,    1'b1);
         chk("dw_read",  p_rd,    1'b0);
         chk("dw_addr",  p_addr,  32'h0000_1000);
         chk("dw_wdata", p_wdata, 256'hDEAD_BEEF);
         cyc();
      end
      p_resp = 1;
      #1;
      chk("dw_dresp", dresp, 1'b1);
      chk("dw_iresp", iresp, 1'b0);
      cyc();
      p_resp = 0;
      #1; chk("dw_done", p_wr, 1'b0);
      cyc();

      // ---- ties: first after reset goes to D, the next to I
      rst_n = 0; cyc(); rst_n = 1;
      ir = 1; iaddr = 32'h0000_2040; dr = 1; daddr = 32'h0000_3080;
      cyc();
      #1;
      chk("tie1_read", p_rd,   1'b1);
      chk("tie1_addr", p_addr, 32'h0000_3080);
      p_resp = 1;
      #1; chk("tie1_dresp", dresp, 1'b1);
      cyc();
      p_resp = 0;
      #1; chk("tie_gap", p_rd, 1'b0);
      cyc();
      #1;
      chk("tie2_read", p_rd,   1'b1);
      chk("tie2_addr", p_addr, 32'h0000_2040);
      p_resp = 1; ir = 0;
      #1; chk("tie2_iresp", iresp, 1'b1);
      cyc();
      p_resp = 0;
      cyc();
      #1; chk("tie3_addr", p_addr, 32'h0000_3080);
      p_resp = 1; dr = 0;
      cyc();
      p_resp = 0;
      cyc();

      // ---- read+write together on D issues a write only
      dr = 1; dw = 1; daddr = 32'h0000_4000; dwdata = 256'h1234;
      cyc();
      dr = 0; dw = 0;
      #1;
      chk("rw_write", p_wr, 1'b1);
      chk("rw_read",  p_rd, 1'b0);
      p_resp = 1;
      cyc();
      p_resp = 0;
      cyc();

      // ---- reset during SERVE_D abandons the transaction
      dr = 1; daddr = 32'h0000_5000;
      cyc();
      dr = 0; rst_n = 0;
      cyc();
      rst_n = 1; p_resp = 1;
      #1;
      chk("ra_read",  p_rd,   1'b0);
      chk("ra_write", p_wr,   1'b0);
      chk("ra_addr",  p_addr, '0);
      chk("ra_dresp", dresp,  1'b0);
      chk("ra_iresp", iresp,  1'b0);
      cyc();
      p_resp = 0;
      cyc();

      // ---- requester drops mid-grant
      ir = 1; iaddr = 32'h0000_6010;
      cyc();
      ir = 0;
      for (int k = 0; k < 3; k++) begin
         #1; chk("drop_hold", p_rd, 1'b1);
         cyc();
      end
      p_resp = 1;
      cyc();
      p_resp = 0;
      #1; chk("drop_idle", p_rd, 1'b0);
      cyc();
      #1; chk("drop_no_reissue", p_rd, 1'b0);
      cyc();

      // ---- randomized traffic against the reference
      for (int n = 0; n < 400; n++) begin
         ir     = ($urandom_range(0, 2) == 0);
         dr     = ($urandom_range(0, 2) == 0);
         dw     = ($urandom_range(0, 3) == 0);
         iaddr  = $urandom;
         daddr  = $urandom;
         for (int k = 0; k < 8; k++) begin
            dwdata[k*32 +: 32]  = $urandom;
            p_rdata[k*32 +: 32] = $urandom;
         end
         p_resp = ($urandom_range(0, 3) == 0);
         rst_n  = ($urandom_range(0, 63) != 0);
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 The block SHALL have parameter LINE_W, default 256: cache line / physical-memory data width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 32: byte address width.
REQ-003 The block SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 The block SHALL have port icache_pmem_read, input, 1: I-cache line-fill request.
REQ-006 The block SHALL have port icache_pmem_address, input, ADDR_W: I-cache request address.
REQ-007 The block SHALL have ports icache_pmem_rdata (output, LINE_W) and icache_pmem_resp (output, 1): fill data and done pulse.
REQ-008 The block SHALL have ports dcache_pmem_read and dcache_pmem_write, input, 1 each: D-cache fill and writeback requests.
REQ-009 The block SHALL have ports dcache_pmem_address (input, ADDR_W) and dcache_pmem_wdata (input, LINE_W): D-cache request address and writeback line.
REQ-010 The block SHALL have ports dcache_pmem_rdata (output, LINE_W) and dcache_pmem_resp (output, 1).
REQ-011 The block SHALL have ports pmem_read, pmem_write (output, 1 each), pmem_address (output, ADDR_W), pmem_wdata (output, LINE_W): shared physical-memory request.
REQ-012 The block SHALL have ports pmem_rdata (input, LINE_W) and pmem_resp (input, 1): physical-memory reply.

Function
REQ-013 The block SHALL implement FSM states IDLE, SERVE_I, SERVE_D.
REQ-014 From IDLE, when exactly one requester is pending, the block SHALL move to that requester's SERVE state on the next edge.
REQ-015 From IDLE, when both are pending, the block SHALL grant the requester not served last; after reset the D-cache wins the first tie.
REQ-016 On every grant edge, the block SHALL latch address, with bits [4:0] forced to 0, plus wdata and op into registers that drive the pmem outputs.
REQ-017 The pmem request SHALL assert in the cycle after the request is first seen in IDLE (1-cycle latency) and SHALL stay stable until pmem_resp.
REQ-018 A D-cache request with read and write both high SHALL be issued as a write only.
REQ-019 In SERVE_x, x_pmem_resp SHALL equal pmem_resp combinationally; the other requester's resp SHALL be 0.
REQ-020 Both *_pmem_rdata outputs SHALL pass pmem_rdata through unregistered; data is valid only with the matching resp.
REQ-021 On pmem_resp, the block SHALL return to IDLE, deassert pmem_read/pmem_write in the next cycle and record x as last-served.
REQ-022 Requester deassertion mid-grant SHALL be ignored; the granted transaction SHALL complete, then the block SHALL return to IDLE.
REQ-023 The block SHALL spend at least one IDLE cycle between transactions, so back-to-back grants are 1 cycle apart after resp.
REQ-024 pmem_resp seen in IDLE SHALL be ignored and SHALL NOT be forwarded to either requester.

Reset
REQ-025 With rst_n low at a clock edge, the FSM SHALL go to IDLE, last-served SHALL be set to I-cache, pmem_read/pmem_write/resp outputs SHALL be 0, and the latched address/wdata SHALL be 0.
REQ-026 Reset mid-transaction SHALL abandon the transaction with no resp to either requester.

Structure
REQ-027 The state enum arb_state_t and the LINE_W/ADDR_W defaults SHALL live in the shared package with the other memory-hierarchy types.
REQ-028 The block SHALL be a single module with no sub-module; FSM and request registers SHALL be inline.

Verification
REQ-029 I-only: icache read to 0x0000_0064 -> pmem_read=1 and pmem_address=0x0000_0060 the next cycle; on pmem_resp with rdata=0xA5..A5, icache_pmem_resp=1 with that data and dcache_pmem_resp=0.
REQ-030 D write: dcache write to 0x0000_1000 with wdata=0xDEAD_BEEF (zero-extended) -> pmem_write=1 with matching address/wdata held through a 5-cycle resp delay.
REQ-031 Tie: both request at once after reset -> D served first, then I after 1 IDLE cycle; a second tie -> I served first.
REQ-032 Read+write high on D-cache -> only pmem_write asserts.
REQ-033 rst_n low during SERVE_D with resp pending -> next cycle is IDLE, all pmem outputs 0, and a later pmem_resp is not forwarded.
REQ-034 Requester drops read mid-grant -> transaction holds until pmem_resp, then IDLE, with no second issue.
